// File: rtl/mult_punto_fijo_seq.sv
// rtl/mult_punto_fijo_seq.sv - sequential signed fixed-point multiplier, radix-2 shift-add with sign fix-up (optional MULT_ZERO_SKIP_EN)
module mult_punto_fijo_seq #(
  parameter int N  = 25,
  parameter int CW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] producto
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SIGNO = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [N-1:0]   ONE_N   = 1;
  localparam logic [2*N-1:0] ONE_2N  = 1;
  localparam logic [CW-1:0]  ONE_CW  = 1;
  localparam logic [CW-1:0]  LAST_IT = CW'(N - 1);

  state_t         state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           signo_q, signo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*N-1:0] producto_q, producto_d;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;

  // Magnitudes of the operands; -2^(N-1) maps to 2^(N-1), which still fits N unsigned bits
  assign mag_a = op_a[N-1] ? (~op_a + ONE_N) : op_a;
  assign mag_b = op_b[N-1] ? (~op_b + ONE_N) : op_b;

  // State and datapath registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      signo_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      producto_q <= '0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      signo_q    <= signo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      producto_q <= producto_d;
    end
  end

  // Next-state and datapath: capture in IDLE, one multiplier bit per RUN cycle, sign fix in SIGNO
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    signo_d    = signo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    producto_d = producto_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{N{1'b0}}, mag_a};
          mplier_d = mag_b;
          signo_d  = op_a[N-1] ^ op_b[N-1];
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
`ifdef MULT_ZERO_SKIP_EN
          if ((op_a == '0) || (op_b == '0)) begin
            producto_d = '0;
            state_d    = FIN;
          end
`endif
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + ONE_CW;
        if (cnt_q == LAST_IT) begin
          state_d = SIGNO;
        end
      end
      SIGNO: begin
        // Negating a zero accumulator yields zero, so no negative zero can appear
        producto_d = signo_q ? (~acc_q + ONE_2N) : acc_q;
        state_d    = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign producto = producto_q;

endmodule

// File: tb/tb_mult_punto_fijo_seq.sv
// tb/tb_mult_punto_fijo_seq.sv - directed and back-to-back checks for mult_punto_fijo_seq
module tb_mult_punto_fijo_seq;

  localparam int N   = 25;
  localparam int LAT = N + 2;
`ifdef MULT_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = N + 2;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] producto;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mult_punto_fijo_seq #(.N(N), .CW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .producto (producto)
  );

  // Issue one operation; lat = rising edges after the accepting edge up to the one that raises done
  task automatic run_op(input longint a, input longint b, output longint prod, output int lat);
    @(negedge clk);
    op_a  = a[N-1:0];
    op_b  = b[N-1:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    prod = longint'($signed(producto));
  endtask

  task automatic test_reset();
    longint p;
    int     l;
    rst_n = 1'b0;
    start = 1'b1;
    op_a  = 25'd16384;
    op_b  = 25'd16384;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || producto !== '0)
      $display("FAIL reset_state got busy=%b done=%b producto=%h exp 0 0 0", busy, done, producto);
    else n_pass++;
    start = 1'b0;
    rst_n = 1'b1;
    run_op(64'sd16384, 64'sd16384, p, l);
    n_total++;
    if (p !== 64'sd268435456) $display("FAIL one_times_one got %0d exp 268435456", p);
    else n_pass++;
    n_total++;
    if (l !== LAT) $display("FAIL one_latency got %0d exp %0d", l, LAT);
    else n_pass++;
  endtask

  task automatic test_signed();
    longint p;
    int     l;
    run_op(-64'sd24576, 64'sd32768, p, l);
    n_total++;
    if (p !== -64'sd805306368) $display("FAIL signed_prod got %0d exp -805306368", p);
    else n_pass++;
    n_total++;
    if (l !== LAT) $display("FAIL signed_latency got %0d exp %0d", l, LAT);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL signed_busy_at_done got %b exp 0", busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL done_one_cycle got %b exp 0", done);
    else n_pass++;
  endtask

  task automatic test_extreme();
    longint p;
    int     l;
    run_op(-64'sd16777216, -64'sd16777216, p, l);
    n_total++;
    if (p !== 64'sd281474976710656) $display("FAIL min_squared got %0d exp 281474976710656", p);
    else n_pass++;
    n_total++;
    if (producto[49] !== 1'b0 || producto[48] !== 1'b1)
      $display("FAIL min_squared_bits got b49=%b b48=%b exp 0 1", producto[49], producto[48]);
    else n_pass++;
    run_op(-64'sd16777216, 64'sd16777215, p, l);
    n_total++;
    if (p !== -64'sd281474959933440) $display("FAIL min_times_max got %0d exp -281474959933440", p);
    else n_pass++;
  endtask

  task automatic test_protocol();
    int     ndone;
    int     lat;
    longint p;
    @(negedge clk);
    op_a  = 25'h1FFFED4;
    op_b  = 25'd1000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL busy_after_start got %b exp 1", busy);
    else n_pass++;
    ndone = 0;
    lat   = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 5) begin
        start = 1'b1;
        op_a  = 25'd7;
        op_b  = 25'd9;
      end
      if (i == 9) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat == 0) lat = i;
      end
    end
    p = longint'($signed(producto));
    n_total++;
    if (p !== -64'sd300000) $display("FAIL ignore_midrun got %0d exp -300000", p);
    else n_pass++;
    n_total++;
    if (ndone !== 1) $display("FAIL single_done got %0d exp 1", ndone);
    else n_pass++;
    n_total++;
    if (lat !== LAT) $display("FAIL protocol_latency got %0d exp %0d", lat, LAT);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int ndone;
    @(negedge clk);
    op_a  = 25'd123;
    op_b  = 25'd456;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_total++;
    if (busy !== 1'b0 || producto !== '0)
      $display("FAIL abort_clear got busy=%b producto=%h exp 0 0", busy, producto);
    else n_pass++;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    n_total++;
    if (ndone !== 0 || producto !== '0)
      $display("FAIL abort_no_done got dones=%0d producto=%h exp 0 0", ndone, producto);
    else n_pass++;
  endtask

  task automatic test_zero();
    longint p;
    int     l;
    run_op(64'sd3, 64'sd5, p, l);
    run_op(64'sd0, -64'sd5, p, l);
    n_total++;
    if (producto !== '0) $display("FAIL zero_times_neg got %h exp 0", producto);
    else n_pass++;
    n_total++;
    if (l !== ZLAT) $display("FAIL zero_latency got %0d exp %0d", l, ZLAT);
    else n_pass++;
    run_op(-64'sd7, 64'sd0, p, l);
    n_total++;
    if (producto !== '0) $display("FAIL neg_times_zero got %h exp 0", producto);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    longint       sa;
    longint       sb;
    longint       p;
    int           l;
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      run_op(sa, sb, p, l);
      n_total++;
      if (p !== sa * sb) $display("FAIL rand_prod[%0d] a=%0d b=%0d got %0d exp %0d", i, sa, sb, p, sa * sb);
      else n_pass++;
      n_total++;
      if (l !== LAT) $display("FAIL rand_latency[%0d] got %0d exp %0d", i, l, LAT);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    test_reset();
    test_signed();
    test_extreme();
    test_protocol();
    test_reset_abort();
    test_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
